// File: rtl/mult_ctrl_if.sv
// mult_ctrl_if: handshake bundle between the lab top level/datapath and the multiplier sequencer
// master: drives start, abort, b_lsb; observes load, add, sft, busy, done, iter
// slave : the sequencer, the reverse direction
interface mult_ctrl_if #(parameter int CW = 3);
  logic start;
  logic abort;
  logic b_lsb;
  logic load;
  logic add;
  logic sft;
  logic busy;
  logic done;
  logic [CW-1:0] iter;
  modport master (output start, abort, b_lsb, input load, add, sft, busy, done, iter);
  modport slave (input start, abort, b_lsb, output load, add, sft, busy, done, iter);
endinterface

// File: rtl/mult_ctrl.sv
// mult_ctrl: Moore sequencer driving load/add/sft strobes of a shift-add multiplier datapath
// clk, rst : rising-edge clock, asynchronous active-high reset
// bus      : start/abort requests and multiplier LSB in; load/add/sft/busy/done strobes and iter out
module mult_ctrl #(
  parameter int WIDTH = 4,
  parameter int CW = 3
) (
  input logic clk,
  input logic rst,
  mult_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, TEST, ADD, SHIFT, DONE} state_t;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t state_q, state_d;
  logic [CW-1:0] iter_q, iter_d;
  logic load_q, add_q, sft_q, busy_q, done_q;
  always_comb begin
    state_d = state_q;
    iter_d = iter_q;
    unique case (state_q)
      IDLE: state_d = bus.start && !bus.abort ? LOAD : IDLE;
      LOAD: begin
        state_d = TEST;
        iter_d = '0;
      end
      TEST: state_d = bus.b_lsb ? ADD : SHIFT;
      ADD: state_d = SHIFT;
      SHIFT: begin
        state_d = iter_q == LAST ? DONE : TEST;
        iter_d = iter_q == LAST ? iter_q : iter_q + 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.abort && state_q != IDLE) begin
      state_d = IDLE;
      iter_d = '0;
    end
  end
  // strobes are registered from the next state so they line up with state_q without decode glitches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      iter_q <= '0;
      load_q <= 1'b0;
      add_q <= 1'b0;
      sft_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q <= iter_d;
      load_q <= state_d == LOAD;
      add_q <= state_d == ADD;
      sft_q <= state_d == SHIFT;
      busy_q <= state_d != IDLE;
      done_q <= state_d == DONE;
    end
  end
  assign bus.load = load_q;
  assign bus.add = add_q;
  assign bus.sft = sft_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.iter = iter_q;
endmodule

// File: tb/tb_mult_ctrl.sv
// tb_mult_ctrl: randomized check of mult_ctrl against a cycle-sequence model and a shift-add datapath model
module tb_mult_ctrl;
  localparam int W = 4;
  localparam int CW = 3;
  typedef struct packed {
    logic load, add, sft, done, busy;
    logic [CW-1:0] it;
    logic chkp;
    logic [7:0] prod;
  } ent_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  mult_ctrl_if #(.CW(CW)) bus();
  mult_ctrl #(.WIDTH(W), .CW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [3:0] da_v = 4'd0, db_v = 4'd0, a, b, pl;
  logic [4:0] ph;
  logic [7:0] prod, last_prod;
  always @(posedge clk) begin
    if (bus.load) begin
      a <= da_v;
      b <= db_v;
      ph <= 5'd0;
      pl <= 4'd0;
    end else if (bus.add) begin
      ph <= {1'b0, ph[3:0]} + {1'b0, a};
    end else if (bus.sft) begin
      ph <= {1'b0, ph[4:1]};
      pl <= {ph[0], pl[3:1]};
      b <= b >> 1;
    end
  end
  assign bus.b_lsb = b[0];
  assign prod = {ph[3:0], pl};
  int n_cmp = 0, n_bad = 0;
  ent_t q[$];
  logic [CW-1:0] last_it = '0, mi = '0;
  bit chk_en = 1'b0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic ent_t mk(logic l, logic ad, logic s, logic d, logic bz, logic [CW-1:0] it, logic cp, logic [7:0] p);
    ent_t e;
    e.load = l;
    e.add = ad;
    e.sft = s;
    e.done = d;
    e.busy = bz;
    e.it = it;
    e.chkp = cp;
    e.prod = p;
    return e;
  endfunction
  task automatic gen(input logic [3:0] d, input logic [CW-1:0] it0, input logic [7:0] p, output ent_t s[$]);
    s = {};
    s.push_back(mk(1, 0, 0, 0, 1, it0, 0, 0));
    for (int i = 0; i < W; i++) begin
      s.push_back(mk(0, 0, 0, 0, 1, CW'(i), 0, 0));
      if (d[i]) s.push_back(mk(0, 1, 0, 0, 1, CW'(i), 0, 0));
      s.push_back(mk(0, 0, 1, 0, 1, CW'(i), 0, 0));
    end
    s.push_back(mk(0, 0, 0, 1, 1, CW'(W - 1), 1, p));
  endtask
  initial forever begin
    ent_t e;
    @(negedge clk);
    if (rst) last_it = '0;
    else if (chk_en) begin
      if (q.size() != 0) e = q.pop_front();
      else e = mk(0, 0, 0, 0, 0, last_it, 0, 0);
      last_it = e.it;
      chk("strobes", 32'({bus.load, bus.add, bus.sft, bus.done, bus.busy}), 32'({e.load, e.add, e.sft, e.done, e.busy}));
      chk("iter", 32'(bus.iter), 32'(e.it));
      if (e.chkp) begin
        chk("product", 32'(prod), 32'(e.prod));
        last_prod = prod;
      end
    end
  end
  task automatic drain();
    for (int t = 0; t < 8 && q.size() != 0; t++) begin
      @(negedge clk);
      #1;
    end
    chk("drain", 32'(q.size()), 32'd0);
  endtask
  task automatic op(input logic [3:0] da, input logic [3:0] db, input int ab_at, input int mode, input bit bb);
    ent_t s[$];
    int n, tot;
    logic [7:0] p;
    p = {4'b0, da} * {4'b0, db};
    gen(db, mi, p, s);
    n = s.size();
    @(posedge clk);
    #1;
    da_v = da;
    db_v = db;
    bus.start = 1'b1;
    bus.abort = 1'b0;
    q.push_back(mk(0, 0, 0, 0, 0, mi, 0, 0));
    if (ab_at > 0) begin
      for (int k = 0; k < ab_at; k++) q.push_back(s[k]);
      q.push_back(mk(0, 0, 0, 0, 0, '0, 0, 0));
      tot = ab_at;
    end else begin
      foreach (s[k]) q.push_back(s[k]);
      tot = n;
      if (bb) begin
        q.push_back(mk(0, 0, 0, 0, 0, CW'(W - 1), 0, 0));
        gen(db, CW'(W - 1), p, s);
        foreach (s[k]) q.push_back(s[k]);
        tot = 2 * n + 1;
      end
    end
    for (int k = 1; k <= tot; k++) begin
      @(posedge clk);
      #1;
      bus.start = bb ? (k <= n + 1) : mode == 1 ? (k <= n && $urandom_range(0, 1) == 1) : mode == 2 ? (k >= 2 && k <= 8) : 1'b0;
      bus.abort = (k == ab_at);
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    mi = ab_at > 0 ? '0 : CW'(W - 1);
    drain();
  endtask
  initial begin
    ent_t s[$];
    logic add_seen;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("reset_outs", 32'({bus.load, bus.add, bus.sft, bus.done, bus.busy}), 32'd0);
    chk("reset_iter", 32'(bus.iter), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    gen(4'b0101, '0, 8'd0, s);
    chk("model_len_0101", 32'(s.size()), 32'd12);
    chk("model_add3", 32'(s[2].add), 32'd1);
    chk("model_sft4", 32'(s[3].sft), 32'd1);
    chk("model_add8", 32'(s[7].add), 32'd1);
    chk("model_done12", 32'(s[11].done), 32'd1);
    gen(4'b0000, '0, 8'd0, s);
    chk("model_len_0000", 32'(s.size()), 32'd10);
    gen(4'b1111, '0, 8'd0, s);
    chk("model_len_1111", 32'(s.size()), 32'd14);
    chk("model_add12", 32'(s[11].add), 32'd1);
    op(4'd3, 4'b0101, 0, 0, 0);
    op(4'd9, 4'b0000, 0, 0, 0);
    op(4'd15, 4'b1111, 0, 0, 0);
    op(4'b1101, 4'b1011, 0, 0, 0);
    chk("prod_143", 32'(last_prod), 32'd143);
    op(4'd3, 4'b0101, 5, 0, 0);
    op(4'd3, 4'b0101, 0, 0, 0);
    op(4'd7, 4'b0101, 0, 2, 0);
    op(4'd9, 4'b0110, 0, 0, 1);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    repeat (3) q.push_back(mk(0, 0, 0, 0, 0, mi, 0, 0));
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    drain();
    chk_en = 1'b0;
    @(posedge clk);
    #1;
    da_v = 4'd5;
    db_v = 4'b0100;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int t = 0; t < 20 && !bus.add; t++) @(negedge clk);
    add_seen = bus.add;
    chk("reached_add", 32'(add_seen), 32'd1);
    chk("iter_in_add", 32'(bus.iter), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_outs", 32'({bus.load, bus.add, bus.sft, bus.done, bus.busy}), 32'd0);
    chk("async_rst_iter", 32'(bus.iter), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mi = '0;
    q.delete();
    chk_en = 1'b1;
    op(4'd6, 4'b1001, 0, 0, 0);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] v;
      int ab;
      v = 8'(i);
      ab = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 10 + $countones(v[3:0])) : 0;
      op(v[7:4], v[3:0], ab, 1, 1'b0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish, required completion within 5ms");
    $fatal(1);
  end
endmodule
